// File: rtl/serial_add_unit_if.sv
// ============================================================================
//  Module   : serial_add_unit_if
//  Brief    : Start/done handshake and operand/result bundle for serial_add_unit.
//             `sub` exists only when SERIAL_ADD_SUB_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

`default_nettype wire

// File: rtl/serial_add_unit.sv
// ============================================================================
//  Module   : serial_add_unit
//  Brief    : Bit-serial adder (optional subtractor via SERIAL_ADD_SUB_EN)
//             driving one fulladder cell, one bit per cycle, LSB first.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_unit_if.slave bus
);
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_s_sh;
    logic               r_c_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_s;
    logic               w_cout;
    logic [WIDTH-1:0]   w_s_next;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_init;
    logic               w_unused;

`ifdef SERIAL_ADD_SUB_EN
    // a - b computed as a + ~b + 1
    assign w_b_load = bus.sub ? ~bus.b : bus.b;
    assign w_c_init = bus.sub;
`else
    assign w_b_load = bus.b;
    assign w_c_init = 1'b0;
`endif

    fulladder u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_c_q),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_s_next = {w_s, r_s_sh[WIDTH-1:1]};
    // LSB of the sum shifter falls off the end on every shift
    assign w_unused = r_s_sh[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_c_q   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= w_b_load;
                        r_c_q   <= w_c_init;
                        r_cnt   <= '0;
                        r_s_sh  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_s_sh <= w_s_next;
                    r_c_q  <= w_cout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_cout;
                        r_ovf   <= r_c_q ^ w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_unit.sv
// ============================================================================
//  Module   : tb_serial_add_unit
//  Brief    : Directed self-checking bench for serial_add_unit (WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic sub_v;

    serial_add_unit_if #(.WIDTH(WIDTH)) bus ();

    serial_add_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef SERIAL_ADD_SUB_EN
    assign bus.sub = sub_v;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.a     = a;
        bus.b     = b;
        sub_v     = s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; pokes start at poke_at.
    task automatic wait_done(input int poke_at, output int n, output logic busy_ok);
        n       = 0;
        busy_ok = bus.busy & ~bus.done;
        while (!bus.done && n < 40) begin
            if (n == poke_at) begin
                bus.a     = 32'hDEAD_BEEF;
                bus.b     = 32'h1234_5678;
                sub_v     = 1'b1;
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            n++;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
            if (bus.done && bus.busy)   busy_ok = 1'b0;
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] esum, input logic ecout,
                         input logic eovf, input int poke_at);
        int   n;
        logic ok;
        start_op(a, b, s);
        wait_done(poke_at, n, ok);
        check({tag, "_lat"}, n, 32'd32);
        check({tag, "_busy"}, {31'd0, ok}, 32'd1);
        check({tag, "_sum"}, bus.sum, esum);
        check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ecout});
        check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eovf});
        tick();
        check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_hold"}, bus.sum, esum);
    endtask

    initial begin
        int   n;
        int   pulses;
        logic ok;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        sub_v     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum", bus.sum, 32'd0);
        check("rst_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op("add5_3", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, -1);
        do_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, -1);
        do_op("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, -1);
        do_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, -1);
        do_op("alt", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
`ifdef SERIAL_ADD_SUB_EN
        do_op("sub5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, -1);
        do_op("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, -1);
`endif

        // Start during RUN ignored, then back-to-back start in the DONE cycle
        start_op(32'd10, 32'd20, 1'b0);
        wait_done(10, n, ok);
        check("ign_lat", n, 32'd32);
        check("ign_busy", {31'd0, ok}, 32'd1);
        check("ign_sum", bus.sum, 32'd30);
        check("ign_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
        start_op(32'd100, 32'd23, 1'b0);
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        check("b2b_done", {31'd0, bus.done}, 32'd0);
        check("b2b_hold", bus.sum, 32'd30);
        wait_done(-1, n, ok);
        check("b2b_lat", n, 32'd32);
        check("b2b_sum", bus.sum, 32'd123);
        tick();

        // Asynchronous reset mid-RUN
        start_op(32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
        for (int i = 1; i < 12; i++) tick();
        check("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_done", {31'd0, bus.done}, 32'd0);
        check("mid_sum", bus.sum, 32'd0);
        check("mid_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
        tick();
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) pulses++;
        end
        check("mid_nopulse", pulses, 32'd0);
        do_op("post_rst", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
